// File: rtl/dn_ct_pkg.sv
// dn_ct_pkg: shared state encoding and default sizing for the reload sequencer
package dn_ct_pkg;
    localparam int DEF_W     = 3;
    localparam int DEF_DEPTH = 4;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/dn_ct_reload_seq_reload_fifo.sv
// reload_fifo: synchronous DEPTHxW FIFO holding pending reload values
module reload_fifo
    import dn_ct_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [AW:0] ONE = 1;
    localparam logic [AW:0] WRAP = {1'b1, {AW{1'b0}}};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    assign empty = wp == rp;
    assign full  = (wp ^ rp) == WRAP;
    assign level = LW'(wp - rp);
    assign head  = mem[rp[AW-1:0]];

    // storage array; callers only push when not full
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end

    // pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + ONE;
            if (pop)  rp <= rp + ONE;
        end
    end
endmodule

// File: rtl/dn_ct_reload_seq.sv
// dn_ct_reload_seq: feeds queued reload values to a down counter each time it reaches zero
module dn_ct_reload_seq
    import dn_ct_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic                         wr_valid,
    input  logic [W-1:0]                 wr_data,
    output logic                         wr_ready,
    input  logic                         flush,
    input  logic [W-1:0]                 cnt,
    output logic                         load,
    output logic [W-1:0]                 data,
    output logic                         busy,
    output logic                         underrun,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [7:0]                   loads_done
);
    state_t       state, state_nx;
    logic         underrun_nx;
    logic         full, empty;
    logic [W-1:0] head;

    assign wr_ready = !full && !flush;
    assign load     = !flush && !empty && (state == IDLE || cnt == '0);
    assign data     = load ? head : '0;
    assign busy     = state == RUN;

    reload_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .areset (areset),
        .push   (wr_valid && wr_ready),
        .pop    (load),
        .flush  (flush),
        .din    (wr_data),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    // next state: a load keeps or enters RUN; a zero count with nothing queued drops to IDLE
    always_comb begin
        state_nx    = state;
        underrun_nx = 1'b0;
        if (flush) state_nx = IDLE;
        else if (load) state_nx = RUN;
        else if (state == RUN && cnt == '0) begin
            state_nx    = IDLE;
            underrun_nx = 1'b1;
        end
    end

    // state, underrun pulse and saturating load counter
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            underrun   <= 1'b0;
            loads_done <= '0;
        end else begin
            state      <= state_nx;
            underrun   <= underrun_nx;
            loads_done <= loads_done + {7'd0, load && loads_done != 8'hFF};
        end
    end
endmodule

// File: tb/tb_dn_ct_reload_seq.sv
// tb_dn_ct_reload_seq: directed checks of the reload sequencer driving a 3-bit down counter
module tb_dn_ct_reload_seq;
    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_data = '0;
    logic       wr_ready;
    logic       flush = 1'b0;
    logic [2:0] q;
    logic       load;
    logic [2:0] data;
    logic       busy;
    logic       underrun;
    logic [2:0] level;
    logic [7:0] loads_done;
    int n_pass = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    dn_ct_reload_seq dut (
        .clk(clk), .areset(areset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .flush(flush), .cnt(q), .load(load), .data(data),
        .busy(busy), .underrun(underrun), .level(level), .loads_done(loads_done)
    );

    // behavioural 3-bit asynchronous-reset down counter downstream of the sequencer
    always_ff @(posedge clk or posedge areset) begin
        if (areset) q <= '0;
        else if (load) q <= data;
        else q <= q - 3'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_chk++; if (load !== 1'b0) $display("FAIL rst_load got %0d want 0", load); else n_pass++;
        step(); step();
        areset = 1'b0;
        #2;
        n_chk++; if (load !== 1'b0) $display("FAIL rst_load2 got %0d want 0", load); else n_pass++;
        n_chk++; if (data !== 3'd0) $display("FAIL rst_data got %0d want 0", data); else n_pass++;
        n_chk++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready got %0d want 1", wr_ready); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %0d want 0", busy); else n_pass++;
        n_chk++; if (underrun !== 1'b0) $display("FAIL rst_underrun got %0d want 0", underrun); else n_pass++;
        n_chk++; if (level !== 3'd0) $display("FAIL rst_level got %0d want 0", level); else n_pass++;
        n_chk++; if (loads_done !== 8'd0) $display("FAIL rst_loads got %0d want 0", loads_done); else n_pass++;
    endtask

    task automatic test_single();
        step(); wr_valid = 1'b1; wr_data = 3'd6; #2;
        step(); wr_valid = 1'b0; #2;
        n_chk++; if (load !== 1'b1) $display("FAIL single_load got %0d want 1", load); else n_pass++;
        n_chk++; if (data !== 3'd6) $display("FAIL single_data got %0d want 6", data); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL single_busy_idle got %0d want 0", busy); else n_pass++;
        for (int k = 6; k >= 0; k--) begin
            step(); #2;
            n_chk++; if (q !== 3'(k)) $display("FAIL single_cnt got %0d want %0d", q, k); else n_pass++;
            n_chk++; if (busy !== 1'b1) $display("FAIL single_busy got %0d want 1", busy); else n_pass++;
            n_chk++; if (load !== 1'b0) $display("FAIL single_noload got %0d want 0", load); else n_pass++;
        end
        n_chk++; if (loads_done !== 8'd1) $display("FAIL single_loads got %0d want 1", loads_done); else n_pass++;
        step(); #2;
        n_chk++; if (underrun !== 1'b1) $display("FAIL single_underrun got %0d want 1", underrun); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL single_busy_end got %0d want 0", busy); else n_pass++;
        step(); #2;
        n_chk++; if (underrun !== 1'b0) $display("FAIL single_underrun_pulse got %0d want 0", underrun); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp [7] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0};
        step(); wr_valid = 1'b1; wr_data = 3'd3; #2;
        step(); wr_data = 3'd2; #2;
        n_chk++; if (load !== 1'b1 || data !== 3'd3) $display("FAIL b2b_first load=%0d data=%0d want 1/3", load, data); else n_pass++;
        step(); wr_valid = 1'b0; #2;
        n_chk++; if (level !== 3'd1) $display("FAIL b2b_level got %0d want 1", level); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin step(); #2; end
            n_chk++; if (q !== exp[i]) $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, q, exp[i]); else n_pass++;
            n_chk++; if (load !== (i == 3)) $display("FAIL b2b_load[%0d] got %0d want %0d", i, load, i == 3); else n_pass++;
            n_chk++; if (busy !== 1'b1) $display("FAIL b2b_busy[%0d] got %0d want 1", i, busy); else n_pass++;
        end
        step(); #2;
        n_chk++; if (underrun !== 1'b1) $display("FAIL b2b_underrun got %0d want 1", underrun); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL b2b_busy_end got %0d want 0", busy); else n_pass++;
        n_chk++; if (loads_done !== 8'd3) $display("FAIL b2b_loads got %0d want 3", loads_done); else n_pass++;
    endtask

    task automatic test_zero_reload();
        step(); wr_valid = 1'b1; wr_data = 3'd0; #2;
        step(); wr_data = 3'd1; #2;
        n_chk++; if (load !== 1'b1 || data !== 3'd0) $display("FAIL zero_first load=%0d data=%0d want 1/0", load, data); else n_pass++;
        step(); wr_valid = 1'b0; #2;
        n_chk++; if (q !== 3'd0) $display("FAIL zero_cnt0 got %0d want 0", q); else n_pass++;
        n_chk++; if (load !== 1'b1 || data !== 3'd1) $display("FAIL zero_second load=%0d data=%0d want 1/1", load, data); else n_pass++;
        step(); #2;
        n_chk++; if (q !== 3'd1 || load !== 1'b0) $display("FAIL zero_cnt1 cnt=%0d load=%0d want 1/0", q, load); else n_pass++;
        step(); #2;
        n_chk++; if (q !== 3'd0 || load !== 1'b0) $display("FAIL zero_cnt2 cnt=%0d load=%0d want 0/0", q, load); else n_pass++;
        step(); #2;
        n_chk++; if (underrun !== 1'b1) $display("FAIL zero_underrun got %0d want 1", underrun); else n_pass++;
        n_chk++; if (loads_done !== 8'd5) $display("FAIL zero_loads got %0d want 5", loads_done); else n_pass++;
    endtask

    task automatic test_flush_full();
        step(); flush = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 3'(i + 1); #2;
            n_chk++; if (wr_ready !== 1'b0 || level !== 3'd0 || load !== 1'b0) $display("FAIL flushblk[%0d] ready=%0d level=%0d load=%0d want 0/0/0", i, wr_ready, level, load); else n_pass++;
            step();
        end
        flush = 1'b0; wr_data = 3'd7; #2;
        step(); wr_valid = 1'b0; #2;
        n_chk++; if (load !== 1'b1 || data !== 3'd7) $display("FAIL full_load7 load=%0d data=%0d want 1/7", load, data); else n_pass++;
        step(); wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 3'(i + 1); #2;
            n_chk++; if (level !== 3'(i < 4 ? i : 4)) $display("FAIL full_level[%0d] got %0d want %0d", i, level, i < 4 ? i : 4); else n_pass++;
            n_chk++; if (wr_ready !== (i < 4)) $display("FAIL full_ready[%0d] got %0d want %0d", i, wr_ready, i < 4); else n_pass++;
            step();
        end
        wr_valid = 1'b0; #2;
        n_chk++; if (level !== 3'd4 || q !== 3'd2) $display("FAIL full_drop level=%0d cnt=%0d want 4/2", level, q); else n_pass++;
        step(); step(); #2;
        n_chk++; if (q !== 3'd0 || load !== 1'b1 || data !== 3'd1) $display("FAIL flush_pre cnt=%0d load=%0d data=%0d want 0/1/1", q, load, data); else n_pass++;
        flush = 1'b1; #1;
        n_chk++; if (load !== 1'b0 || data !== 3'd0) $display("FAIL flush_force load=%0d data=%0d want 0/0", load, data); else n_pass++;
        step(); flush = 1'b0; #2;
        n_chk++; if (level !== 3'd0 || busy !== 1'b0 || underrun !== 1'b0 || load !== 1'b0) $display("FAIL flush_after level=%0d busy=%0d underrun=%0d load=%0d want 0/0/0/0", level, busy, underrun, load); else n_pass++;
        step(); #2;
        n_chk++; if (underrun !== 1'b0) $display("FAIL flush_no_underrun got %0d want 0", underrun); else n_pass++;
    endtask

    task automatic test_areset();
        step(); wr_valid = 1'b1; wr_data = 3'd6;
        step(); wr_data = 3'd1;
        step(); wr_data = 3'd2;
        step(); wr_valid = 1'b0; #2;
        n_chk++; if (level !== 3'd2 || busy !== 1'b1) $display("FAIL ar_pre level=%0d busy=%0d want 2/1", level, busy); else n_pass++;
        areset = 1'b1; #1; areset = 1'b0; #1;
        n_chk++; if (level !== 3'd0 || busy !== 1'b0 || load !== 1'b0 || data !== 3'd0) $display("FAIL ar_clear level=%0d busy=%0d load=%0d data=%0d want 0/0/0/0", level, busy, load, data); else n_pass++;
        n_chk++; if (wr_ready !== 1'b1 || underrun !== 1'b0 || loads_done !== 8'd0) $display("FAIL ar_clear2 ready=%0d underrun=%0d loads=%0d want 1/0/0", wr_ready, underrun, loads_done); else n_pass++;
        step(); wr_valid = 1'b1; wr_data = 3'd7; #2;
        step(); wr_valid = 1'b0; #2;
        n_chk++; if (load !== 1'b1 || data !== 3'd7) $display("FAIL ar_reload load=%0d data=%0d want 1/7", load, data); else n_pass++;
        step(); #2;
        n_chk++; if (q !== 3'd7 || loads_done !== 8'd1) $display("FAIL ar_cnt cnt=%0d loads=%0d want 7/1", q, loads_done); else n_pass++;
        step(); flush = 1'b1;
        step(); flush = 1'b0;
    endtask

    task automatic test_saturation();
        step(); wr_valid = 1'b1; wr_data = 3'd0;
        for (int k = 1; k <= 260; k++) begin
            step(); #2;
            if (k == 100) begin
                n_chk++; if (loads_done !== 8'd100 || load !== 1'b1) $display("FAIL sat_mid loads=%0d load=%0d want 100/1", loads_done, load); else n_pass++;
            end
        end
        wr_valid = 1'b0;
        step(); step(); #2;
        n_chk++; if (underrun !== 1'b1) $display("FAIL sat_underrun got %0d want 1", underrun); else n_pass++;
        n_chk++; if (loads_done !== 8'd255) $display("FAIL sat_loads got %0d want 255", loads_done); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_reload();
        test_flush_full();
        test_areset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
